// File: rtl/tcdm_interco_pkg.sv
// Shared definitions for the TCDM interconnect slice: index width helper
// and the stage record carried through the bank response pipeline.
package tcdm_interco_pkg;

    // Upper bound on master-index width stored in a pipeline stage.
    localparam int unsigned MaxIdxW = 16;

    // Number of bits needed to name one of n masters, never less than one.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // One stage of the response pipeline: was there a handshake, and for whom.
    typedef struct packed {
        logic               vld;
        logic [MaxIdxW-1:0] idx;
    } resp_stage_t;

endpackage

// File: rtl/tcdm_rr_pick.sv
// Combinational rotate-priority picker: scans the request vector starting
// at the round-robin pointer and wraps, returning the first requester.
module tcdm_rr_pick
    import tcdm_interco_pkg::*;
#(
    parameter int unsigned NumMaster = 4,
    parameter int unsigned IdxW      = idx_width(NumMaster)
) (
    input  logic [NumMaster-1:0] req_i,
    input  logic [IdxW-1:0]      rr_i,
    output logic [IdxW-1:0]      winner_o,
    output logic                 any_o
);

    logic [IdxW:0] cand;

    // Walk offsets 0..NumMaster-1 from the pointer; first hit wins, else keep the pointer.
    always_comb begin
        winner_o = rr_i;
        any_o    = 1'b0;
        cand     = '0;
        for (int unsigned off = 0; off < NumMaster; off++) begin
            cand = {1'b0, rr_i} + (IdxW+1)'(off);
            if (cand >= (IdxW+1)'(NumMaster)) begin
                cand = cand - (IdxW+1)'(NumMaster);
            end
            if (!any_o && req_i[cand[IdxW-1:0]]) begin
                winner_o = cand[IdxW-1:0];
                any_o    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/tcdm_bank_rr_arb.sv
// Per-bank round-robin arbiter: shares one TCDM bank among NumMaster
// masters, forwards the winner's payload and routes the read-valid back to
// the granted master after the bank latency.
module tcdm_bank_rr_arb
    import tcdm_interco_pkg::*;
#(
    parameter int unsigned NumMaster     = 4,
    parameter int unsigned ReqDataWidth  = 32,
    parameter int unsigned RespDataWidth = 32,
    parameter int unsigned RespLat       = 1
) (
    input  logic                                    clk_i,
    input  logic                                    rst_ni,
    input  logic [NumMaster-1:0]                    req_i,
    input  logic [NumMaster-1:0][ReqDataWidth-1:0]  data_i,
    output logic [NumMaster-1:0]                    gnt_o,
    output logic [NumMaster-1:0]                    rvld_o,
    output logic [RespDataWidth-1:0]                rdata_o,
    output logic                                    req_o,
    input  logic                                    gnt_i,
    output logic [ReqDataWidth-1:0]                 data_o,
    input  logic [RespDataWidth-1:0]                rdata_i
);

    localparam int unsigned IdxW = idx_width(NumMaster);

    logic [IdxW-1:0] rr_q;
    logic [IdxW-1:0] winner;
    logic            any_req;
    logic            hs;
    resp_stage_t     pipe_q [RespLat];

    tcdm_rr_pick #(
        .NumMaster (NumMaster),
        .IdxW      (IdxW)
    ) u_pick (
        .req_i    (req_i),
        .rr_i     (rr_q),
        .winner_o (winner),
        .any_o    (any_req)
    );

    assign req_o   = any_req;
    assign hs      = req_o & gnt_i;
    assign rdata_o = rdata_i;

    // Steer the grant and the payload mux from the current winner.
    always_comb begin
        gnt_o  = '0;
        data_o = '0;
        for (int unsigned m = 0; m < NumMaster; m++) begin
            if (winner == IdxW'(m)) begin
                gnt_o[m] = hs;
                data_o   = data_i[m];
            end
        end
    end

    // Advance the priority pointer past the winner only when the bank accepts.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rr_q <= '0;
        end else if (hs) begin
            rr_q <= (winner == IdxW'(NumMaster-1)) ? '0 : winner + IdxW'(1);
        end
    end

    // Carry each handshake and its master index through the bank latency.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int unsigned k = 0; k < RespLat; k++) begin
                pipe_q[k] <= '0;
            end
        end else begin
            pipe_q[0] <= '{vld: hs, idx: MaxIdxW'(winner)};
            for (int unsigned k = 1; k < RespLat; k++) begin
                pipe_q[k] <= pipe_q[k-1];
            end
        end
    end

    // Decode the last pipeline stage into a one-hot response valid.
    always_comb begin
        rvld_o = '0;
        for (int unsigned m = 0; m < NumMaster; m++) begin
            rvld_o[m] = pipe_q[RespLat-1].vld &&
                        (pipe_q[RespLat-1].idx == MaxIdxW'(m));
        end
    end

endmodule

// File: tb/tb_tcdm_bank_rr_arb.sv
// Bench for tcdm_bank_rr_arb: two instances (4 masters / latency 3 and
// 3 masters / latency 1) driven in lock-step against a reference model
// with a scoreboard queue of expected read-valids.
module tb_tcdm_bank_rr_arb;

    localparam int NA = 4;
    localparam int LA = 3;
    localparam int NB = 3;
    localparam int LB = 1;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic [NA-1:0]         req_a = '0;
    logic [NA-1:0][DW-1:0] data_a = '0;
    logic [NA-1:0]         gnt_a;
    logic [NA-1:0]         rvld_a;
    logic [DW-1:0]         rdata_a_o;
    logic                  breq_a;
    logic                  bgnt_a = 1'b0;
    logic [DW-1:0]         bdata_a;
    logic [DW-1:0]         brdata_a = '0;

    logic [NB-1:0]         req_b = '0;
    logic [NB-1:0][DW-1:0] data_b = '0;
    logic [NB-1:0]         gnt_b;
    logic [NB-1:0]         rvld_b;
    logic [DW-1:0]         rdata_b_o;
    logic                  breq_b;
    logic                  bgnt_b = 1'b0;
    logic [DW-1:0]         bdata_b;
    logic [DW-1:0]         brdata_b = '0;

    typedef struct {
        int         due;
        logic [3:0] mask;
    } exp_t;

    exp_t sb_a[$];
    exp_t sb_b[$];
    int   rr_a = 0;
    int   rr_b = 0;
    int   cyc = 0;
    int   compare_count = 0;
    int   fail_count = 0;
    int   cnt_b [NB];

    always #5 clk = ~clk;

    tcdm_bank_rr_arb #(
        .NumMaster(NA), .ReqDataWidth(DW), .RespDataWidth(DW), .RespLat(LA)
    ) dut_a (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req_a), .data_i(data_a),
        .gnt_o(gnt_a), .rvld_o(rvld_a), .rdata_o(rdata_a_o), .req_o(breq_a),
        .gnt_i(bgnt_a), .data_o(bdata_a), .rdata_i(brdata_a)
    );

    tcdm_bank_rr_arb #(
        .NumMaster(NB), .ReqDataWidth(DW), .RespDataWidth(DW), .RespLat(LB)
    ) dut_b (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req_b), .data_i(data_b),
        .gnt_o(gnt_b), .rvld_o(rvld_b), .rdata_o(rdata_b_o), .req_o(breq_b),
        .gnt_i(bgnt_b), .data_o(bdata_b), .rdata_i(brdata_b)
    );

    // Reference round-robin pick: first requester from rr upward, wrapping.
    function automatic int pick(input logic [3:0] req, input int rr, input int n);
        for (int off = 0; off < n; off++) begin
            int c;
            c = (rr + off) % n;
            if (req[c]) return c;
        end
        return rr;
    endfunction

    // Count one comparison and report it if observed differs from expected.
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compare_count++;
        if (obs !== exp) begin
            fail_count++;
            $display("[TB] FAIL %s cycle %0d: got %h expected %h", tag, cyc, obs, exp);
        end
    endtask

    // Drive one cycle on both instances, check outputs, then step the model.
    task automatic applyStimulus(input logic rst_val, input logic [3:0] ra, input logic ga,
                                 input logic [2:0] rb, input logic gb);
        int         wa, wb;
        logic       hsa, hsb;
        logic [3:0] ev;
        @(negedge clk);
        rst_n = rst_val;
        req_a = ra;
        bgnt_a = ga;
        req_b = rb;
        bgnt_b = gb;
        for (int m = 0; m < NA; m++) data_a[m] = $urandom;
        for (int m = 0; m < NB; m++) data_b[m] = $urandom;
        brdata_a = $urandom;
        brdata_b = $urandom;
        #1;

        wa  = pick(ra, rr_a, NA);
        hsa = (|ra) & ga;
        checkOutput("gnt_a", 32'(gnt_a), hsa ? 32'(1 << wa) : 32'd0);
        checkOutput("req_a", 32'(breq_a), 32'(|ra));
        checkOutput("data_a", bdata_a, data_a[wa]);
        checkOutput("rdata_a", rdata_a_o, brdata_a);
        ev = '0;
        if (sb_a.size() > 0 && sb_a[0].due == cyc) ev = sb_a.pop_front().mask;
        checkOutput("rvld_a", 32'(rvld_a), 32'(ev));

        wb  = pick({1'b0, rb}, rr_b, NB);
        hsb = (|rb) & gb;
        checkOutput("gnt_b", 32'(gnt_b), hsb ? 32'(1 << wb) : 32'd0);
        checkOutput("req_b", 32'(breq_b), 32'(|rb));
        checkOutput("data_b", bdata_b, data_b[wb]);
        checkOutput("rdata_b", rdata_b_o, brdata_b);
        ev = '0;
        if (sb_b.size() > 0 && sb_b[0].due == cyc) ev = sb_b.pop_front().mask;
        checkOutput("rvld_b", 32'(rvld_b), 32'(ev));

        if (!rst_val) begin
            rr_a = 0;
            rr_b = 0;
            sb_a.delete();
            sb_b.delete();
        end else begin
            if (hsa) begin
                rr_a = (wa + 1) % NA;
                sb_a.push_back('{due: cyc + LA, mask: 4'(1 << wa)});
            end
            if (hsb) begin
                rr_b = (wb + 1) % NB;
                sb_b.push_back('{due: cyc + LB, mask: 4'(1 << wb)});
            end
        end
        cyc++;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        applyStimulus(1'b0, 4'b0000, 1'b0, 3'b000, 1'b0);
        applyStimulus(1'b1, 4'b0000, 1'b0, 3'b000, 1'b0);

        // Three masters all requesting: six handshakes, two each.
        for (int m = 0; m < NB; m++) cnt_b[m] = 0;
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b1, 4'b0000, 1'b0, 3'b111, 1'b1);
            for (int m = 0; m < NB; m++) if (gnt_b[m]) cnt_b[m]++;
        end
        for (int m = 0; m < NB; m++) checkOutput($sformatf("cnt_b%0d", m), 32'(cnt_b[m]), 32'd2);

        // All four requesting for eight cycles: rotating grant.
        for (int i = 0; i < 8; i++) applyStimulus(1'b1, 4'b1111, 1'b1, 3'b000, 1'b0);
        for (int i = 0; i < LA; i++) applyStimulus(1'b1, 4'b0000, 1'b0, 3'b000, 1'b0);

        // Grants to 2, 0 (wrap-around from pointer 3), 3 back-to-back.
        applyStimulus(1'b1, 4'b0100, 1'b1, 3'b000, 1'b0);
        applyStimulus(1'b1, 4'b0001, 1'b1, 3'b000, 1'b0);
        applyStimulus(1'b1, 4'b1000, 1'b1, 3'b000, 1'b0);
        for (int i = 0; i < LA; i++) applyStimulus(1'b1, 4'b0000, 1'b0, 3'b000, 1'b0);

        // Bank stall with masters 1 and 2 requesting, then release.
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 4'b0110, 1'b0, 3'b011, 1'b0);
        applyStimulus(1'b1, 4'b0110, 1'b1, 3'b011, 1'b1);
        for (int i = 0; i < LA; i++) applyStimulus(1'b1, 4'b0000, 1'b0, 3'b000, 1'b0);

        // Grant in flight, then reset: response discarded, restart at master 0.
        applyStimulus(1'b1, 4'b0010, 1'b1, 3'b010, 1'b1);
        applyStimulus(1'b0, 4'b0000, 1'b0, 3'b000, 1'b0);
        for (int i = 0; i < LA + 1; i++) applyStimulus(1'b1, 4'b1111, 1'b1, 3'b111, 1'b1);

        // Random traffic including stalls.
        for (int i = 0; i < 300; i++) begin
            applyStimulus(($urandom_range(0, 49) != 0), 4'($urandom), ($urandom_range(0, 3) != 0),
                          3'($urandom), ($urandom_range(0, 3) != 0));
        end
        for (int i = 0; i < LA + 1; i++) applyStimulus(1'b1, 4'b0000, 1'b0, 3'b000, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, fail_count);
        $finish;
    end

endmodule
